// File: rtl/vga_fb_read_arbiter_if.sv
// Shared pixel-RAM bus: RAM strobes, address and data, plus the pixel-writer request/ack pair.
// The arbiter takes the master side; the RAM and the writer sit on the slave side.
interface vga_fb_read_arbiter_if #(
  parameter int ADDR_W = 20
);
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_RD;
  logic              MEM_WR;
  logic [23:0]       MEM_WDATA;
  logic [23:0]       MEM_RDATA;
  logic              WR_REQ;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [23:0]       WR_DATA;
  logic              WR_ACK;

  modport master (
    output MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA, WR_ACK,
    input  MEM_RDATA, WR_REQ, WR_ADDR, WR_DATA
  );

  modport slave (
    input  MEM_ADDR, MEM_RD, MEM_WR, MEM_WDATA, WR_ACK,
    output MEM_RDATA, WR_REQ, WR_ADDR, WR_DATA
  );
endinterface

// File: rtl/vga_fb_read_arbiter.sv
// Shares one pixel RAM between display prefetch (into a show-ahead FIFO) and a pixel writer.
// Latency: grant in n, MEM_* in n+1, read data pushed at the end of n+2 (head visible n+3).
// Backpressure: writer holds WR_REQ until WR_ACK; display reads stop once FIFO + in-flight fills it.
module vga_fb_read_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int H_ACT      = 1024,
  parameter int V_ACT      = 768,
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 8
) (
  input  logic                        VGA_CLK,
  input  logic                        VGA_RST_N,
  input  logic                        VGA_VSYNC,
  input  logic                        VGA_IF_RGBEN,
  output logic [23:0]                 VGA_BUF_RGB,
  output logic                        UNDERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  vga_fb_read_arbiter_if.master       bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACT * V_ACT - 1);
  localparam logic [OW-1:0]     LOW_WM_O  = OW'(LOW_WM);
  localparam logic [OW-1:0]     DEPTH_O   = OW'(FIFO_DEPTH);

  typedef enum logic {SYNC_WAIT = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              vsync_q;
  logic              fsync;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ret;
  logic [OW-1:0]     occ;
  logic              gnt_rd, gnt_wr;
  logic              push, pop, fifo_empty;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [23:0]       fifo_mem [FIFO_DEPTH];

  assign fsync = vsync_q && !VGA_VSYNC;
  // In-flight reads are exactly the read strobe on the bus plus the word returning now.
  assign occ   = OW'(FIFO_LEVEL) + OW'(bus.MEM_RD) + OW'(rd_ret);

  always_comb begin
    state_d = state_q;
    gnt_rd  = 1'b0;
    gnt_wr  = 1'b0;
    if (fsync) state_d = RUN;
    if (state_q == RUN && !fsync && occ <= LOW_WM_O) gnt_rd = 1'b1;
    else if (bus.WR_REQ && !bus.WR_ACK)               gnt_wr = 1'b1;
    else if (state_q == RUN && !fsync && occ < DEPTH_O) gnt_rd = 1'b1;
  end

  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      state_q       <= SYNC_WAIT;
      vsync_q       <= 1'b0;
      rd_addr       <= '0;
      rd_ret        <= 1'b0;
      UNDERFLOW     <= 1'b0;
      bus.MEM_ADDR  <= '0;
      bus.MEM_RD    <= 1'b0;
      bus.MEM_WR    <= 1'b0;
      bus.MEM_WDATA <= '0;
      bus.WR_ACK    <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= VGA_VSYNC;
      bus.MEM_RD <= gnt_rd;
      bus.MEM_WR <= gnt_wr;
      bus.WR_ACK <= gnt_wr;
      // A read on the bus during the flush cycle returns stale data; drop it.
      rd_ret     <= bus.MEM_RD && !fsync;
      if (gnt_rd) begin
        bus.MEM_ADDR <= rd_addr;
      end else if (gnt_wr) begin
        bus.MEM_ADDR  <= bus.WR_ADDR;
        bus.MEM_WDATA <= bus.WR_DATA;
      end
      if (fsync)       rd_addr <= '0;
      else if (gnt_rd) rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
      if (fsync)                          UNDERFLOW <= 1'b0;
      else if (VGA_IF_RGBEN && fifo_empty) UNDERFLOW <= 1'b1;
    end
  end

  assign fifo_empty  = (FIFO_LEVEL == '0);
  assign pop         = VGA_IF_RGBEN && !fifo_empty;
  assign push        = rd_ret && !fsync;
  assign VGA_BUF_RGB = fifo_empty ? 24'h0 : fifo_mem[rd_ptr];

  always_ff @(posedge VGA_CLK) begin
    if (push) fifo_mem[wr_ptr] <= bus.MEM_RDATA;
  end

  always_ff @(posedge VGA_CLK or negedge VGA_RST_N) begin
    if (!VGA_RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
    end else if (fsync) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_LEVEL <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   FIFO_LEVEL <= FIFO_LEVEL + 1'b1;
        2'b01:   FIFO_LEVEL <= FIFO_LEVEL - 1'b1;
        default: FIFO_LEVEL <= FIFO_LEVEL;
      endcase
    end
  end
endmodule
